// File: rtl/ct_cal_date.sv
// Calendar date counter: day-of-month, month, year and day-of-week.
// Advances one day per en tick and accepts a parallel date load for setting
// the clock. Gregorian leap-year handling can be disabled for legacy builds.
module ct_cal_date #(
  parameter int YEAR_W     = 12,
  parameter int RESET_YEAR = 2000,
  parameter int RESET_DOW  = 6,
  parameter int LEAP_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  input  logic [2:0]        ld_dow,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [2:0]        dow,
  output logic              leap,
  output logic              z,
  output logic              z_year
);

  // Leap test without a divider. A multiple of 4 is a multiple of 100 exactly
  // when it is a multiple of 25, and a multiple of 400 exactly when it is a
  // multiple of both 16 and 25. The remainder mod 25 comes from a restoring
  // subtract chain against shifted copies of the constant 25.
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [YEAR_W+4:0] r;
    logic [YEAR_W+4:0] d;
    r = {5'd0, y};
    for (int k = YEAR_W - 1; k >= 0; k--) begin
      d = (YEAR_W + 5)'(25) << k;
      if (r >= d) r = r - d;
    end
    is_leap = (LEAP_EN != 0) && (y[1:0] == 2'b00) &&
              ((r != '0) || (y[3:0] == 4'b0000));
  endfunction

  // Index of the last day of a month (month length minus one).
  function automatic logic [4:0] last_day(input logic [3:0] m, input logic lp);
    case (m)
      4'd1:                      last_day = lp ? 5'd28 : 5'd27;
      4'd3, 4'd5, 4'd8, 4'd10:   last_day = 5'd29;
      default:                   last_day = 5'd30;
    endcase
  endfunction

  logic [4:0] cur_last;
  logic       wrap_month;
  logic [3:0] ld_month_c;
  logic [2:0] ld_dow_c;
  logic [4:0] ld_last;
  logic [4:0] ld_day_c;

  // Status flags are combinational so upstream logic can gate on en && z.
  // A corrupted day beyond the month end is treated as the last day on the
  // next tick, which pulls the counter back into range.
  assign leap       = is_leap(year);
  assign cur_last   = last_day(month, leap);
  assign z          = (day == cur_last);
  assign z_year     = z && (month == 4'd11);
  assign wrap_month = (day >= cur_last);

  // Load sanitising: clamp month, fold dow 7 to Sunday, and clamp day to the
  // length of the month being loaded (using the loaded year's leap status).
  assign ld_month_c = (ld_month > 4'd11) ? 4'd11 : ld_month;
  assign ld_dow_c   = (ld_dow == 3'd7) ? 3'd0 : ld_dow;
  assign ld_last    = last_day(ld_month_c, is_leap(ld_year));
  assign ld_day_c   = (ld_day > ld_last) ? ld_last : ld_day;

  // Date registers: reset, then load, then daily advance, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      day   <= 5'd0;
      month <= 4'd0;
      year  <= YEAR_W'(RESET_YEAR);
      dow   <= 3'(RESET_DOW);
    end else if (ld) begin
      day   <= ld_day_c;
      month <= ld_month_c;
      year  <= ld_year;
      dow   <= ld_dow_c;
    end else if (en) begin
      dow <= (dow >= 3'd6) ? 3'd0 : dow + 3'd1;
      if (wrap_month) begin
        day <= 5'd0;
        if (month >= 4'd11) begin
          month <= 4'd0;
          year  <= year + YEAR_W'(1);
        end else begin
          month <= month + 4'd1;
        end
      end else begin
        day <= day + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_ct_cal_date.sv
// Directed bench for ct_cal_date. Expected dates are pushed to a scoreboard
// queue as each step is driven and popped when the outputs are sampled.
// A second instance with leap handling disabled covers the legacy February.
module tb_ct_cal_date;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ld;
  logic [4:0]  ld_day;
  logic [3:0]  ld_month;
  logic [11:0] ld_year;
  logic [2:0]  ld_dow;

  logic [4:0]  day;
  logic [3:0]  month;
  logic [11:0] year;
  logic [2:0]  dow;
  logic        leap, z, z_year;

  logic [4:0]  l_day;
  logic [3:0]  l_month;
  logic [11:0] l_year;
  logic [2:0]  l_dow;
  logic        l_leap, l_z, l_z_year;

  typedef struct {
    string       tag;
    bit          legacy;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic [2:0]  dow;
    logic        leap;
    logic        z;
    logic        z_year;
  } exp_t;

  exp_t sb[$];
  int   nvec  = 0;
  int   nfail = 0;

  ct_cal_date dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .ld_dow(ld_dow),
    .day(day), .month(month), .year(year), .dow(dow),
    .leap(leap), .z(z), .z_year(z_year)
  );

  ct_cal_date #(.LEAP_EN(0)) dut_legacy (
    .clk(clk), .rst(rst), .en(en), .ld(ld),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .ld_dow(ld_dow),
    .day(l_day), .month(l_month), .year(l_year), .dow(l_dow),
    .leap(l_leap), .z(l_z), .z_year(l_z_year)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic push_exp(input string tag, input bit legacy, input int d,
                          input int m, input int y, input int w,
                          input bit lp, input bit zz, input bit zy);
    exp_t e;
    e.tag    = tag;
    e.legacy = legacy;
    e.day    = 5'(d);
    e.month  = 4'(m);
    e.year   = 12'(y);
    e.dow    = 3'(w);
    e.leap   = lp;
    e.z      = zz;
    e.z_year = zy;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit l, input bit e, input int d,
                               input int m, input int y, input int w);
    @(negedge clk);
    ld       = l;
    en       = e;
    ld_day   = 5'(d);
    ld_month = 4'(m);
    ld_year  = 12'(y);
    ld_dow   = 3'(w);
    @(posedge clk);
    #1;
    ld = 1'b0;
    en = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [26:0] act;
    logic [26:0] want;
    nvec++;
    if (sb.size() == 0) begin
      nfail++;
      $display("[TB] FAIL scoreboard_empty: observed no entry, expected one");
      return;
    end
    e = sb.pop_front();
    if (e.legacy)
      act = {l_day, l_month, l_year, l_dow, l_leap, l_z, l_z_year};
    else
      act = {day, month, year, dow, leap, z, z_year};
    want = {e.day, e.month, e.year, e.dow, e.leap, e.z, e.z_year};
    assert (act === want) else begin
      nfail++;
      $error("[TB] FAIL %s: observed d=%0d m=%0d y=%0d w=%0d lp=%0b z=%0b zy=%0b, expected d=%0d m=%0d y=%0d w=%0d lp=%0b z=%0b zy=%0b",
             e.tag, act[26:22], act[21:18], act[17:6], act[5:3], act[2], act[1], act[0],
             e.day, e.month, e.year, e.dow, e.leap, e.z, e.z_year);
    end
  endtask

  // Directed sequence.
  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0;
    ld_day = '0; ld_month = '0; ld_year = '0; ld_dow = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset_held", 0, 0, 0, 2000, 6, 1, 0, 0);
    checkOutput();
    push_exp("reset_held_legacy", 1, 0, 0, 2000, 6, 0, 0, 0);
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    push_exp("reset_release_hold", 0, 0, 0, 2000, 6, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput();

    // February in a leap year, with the legacy instance alongside.
    push_exp("feb2024_load", 0, 27, 1, 2024, 4, 1, 0, 0);
    push_exp("feb2024_load_legacy", 1, 27, 1, 2024, 4, 0, 1, 0);
    applyStimulus(1, 0, 27, 1, 2024, 4);
    checkOutput();
    checkOutput();
    push_exp("feb2024_29th", 0, 28, 1, 2024, 5, 1, 1, 0);
    push_exp("feb2024_legacy_mar", 1, 0, 2, 2024, 5, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();
    checkOutput();
    push_exp("feb2024_to_mar", 0, 0, 2, 2024, 6, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();

    // Century years: 1900 is common, 2000 is leap.
    push_exp("feb1900_load", 0, 27, 1, 1900, 1, 0, 1, 0);
    applyStimulus(1, 0, 27, 1, 1900, 1);
    checkOutput();
    push_exp("feb1900_to_mar", 0, 0, 2, 1900, 2, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();
    push_exp("feb2000_load", 0, 27, 1, 2000, 0, 1, 0, 0);
    applyStimulus(1, 0, 27, 1, 2000, 0);
    checkOutput();
    push_exp("feb2000_29th", 0, 28, 1, 2000, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();

    // 30- and 31-day months.
    push_exp("apr30_load", 0, 29, 3, 2023, 2, 0, 1, 0);
    applyStimulus(1, 0, 29, 3, 2023, 2);
    checkOutput();
    push_exp("apr30_to_may", 0, 0, 4, 2023, 3, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();
    push_exp("may30_load", 0, 29, 4, 2023, 2, 0, 0, 0);
    applyStimulus(1, 0, 29, 4, 2023, 2);
    checkOutput();
    push_exp("may30_to_31", 0, 30, 4, 2023, 3, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();

    // Year rollover and year wrap.
    push_exp("dec31_2023_load", 0, 30, 11, 2023, 0, 0, 1, 1);
    applyStimulus(1, 0, 30, 11, 2023, 0);
    checkOutput();
    push_exp("newyear_2024", 0, 0, 0, 2024, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();
    push_exp("dec31_4095_load", 0, 30, 11, 4095, 3, 0, 1, 1);
    applyStimulus(1, 0, 30, 11, 4095, 3);
    checkOutput();
    push_exp("year_wrap_0", 0, 0, 0, 0, 4, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();

    // Seven consecutive ticks bring dow back around.
    push_exp("dow_walk_load", 0, 10, 5, 2020, 3, 1, 0, 0);
    applyStimulus(1, 0, 10, 5, 2020, 3);
    checkOutput();
    for (int i = 1; i <= 7; i++) begin
      push_exp("dow_walk", 0, 10 + i, 5, 2020, (3 + i) % 7, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput();
    end

    // Load sanitising rules.
    push_exp("ld_day_clamp", 0, 27, 1, 2023, 2, 0, 1, 0);
    applyStimulus(1, 0, 31, 1, 2023, 2);
    checkOutput();
    push_exp("ld_month_clamp", 0, 3, 11, 2023, 2, 0, 0, 0);
    applyStimulus(1, 0, 3, 14, 2023, 2);
    checkOutput();
    push_exp("ld_dow_fold", 0, 0, 0, 2023, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 2023, 7);
    checkOutput();
    push_exp("ld_beats_en", 0, 5, 5, 2020, 5, 1, 0, 0);
    applyStimulus(1, 1, 5, 5, 2020, 5);
    checkOutput();
    push_exp("hold", 0, 5, 5, 2020, 5, 1, 0, 0);
    applyStimulus(0, 0, 9, 9, 1234, 1);
    checkOutput();

    // Mid-count asynchronous reset, checked before any clock edge.
    push_exp("count_6", 0, 6, 5, 2020, 6, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();
    push_exp("count_7", 0, 7, 5, 2020, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();
    @(negedge clk);
    en = 1'b1;
    #2 rst = 1'b0;
    #1;
    push_exp("async_reset", 0, 0, 0, 2000, 6, 1, 0, 0);
    checkOutput();
    push_exp("async_reset_legacy", 1, 0, 0, 2000, 6, 0, 0, 0);
    checkOutput();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    push_exp("post_reset_tick", 0, 1, 0, 2000, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();

    if (sb.size() != 0) begin
      nvec++;
      nfail++;
      $display("[TB] FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/ct_cal_date.md
# ct_cal_date

Parametrised calendar date counter: day-of-month, month, year and day-of-week, advanced once per day tick (the hour counter's 23→0 rollover). It sits between the hour counter and the display/alarm compare logic. It generalises the fixed 28/30/31 day counter with:
- full Gregorian leap-year handling (switchable);
- month and year rollover;
- a parallel date load for setting the clock;
- a day-of-week output.

## Interface

Parameters
- YEAR_W, 12: width of the year register; year wraps modulo 2^YEAR_W.
- RESET_YEAR, 2000: year value after reset.
- RESET_DOW, 6: day-of-week after reset (0 = Sunday; 1 Jan 2000 is a Saturday).
- LEAP_EN, 1: 1 = February has 29 days in leap years; 0 = February is always 28 days (legacy behaviour).

Ports
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  day tick, one cycle per day.
- ld  in  1  load strobe; has priority over en.
- ld_day  in  5  day to load, 0-based (0 = 1st).
- ld_month  in  4  month to load, 0-based (0 = Jan, 11 = Dec).
- ld_year  in  YEAR_W  year to load.
- ld_dow  in  3  day-of-week to load, 0..6.
- day  out  5  current day, 0-based.
- month  out  4  current month, 0-based.
- year  out  YEAR_W  current year.
- dow  out  3  current day-of-week, 0..6.
- leap  out  1  current year is a leap year (forced 0 when LEAP_EN = 0).
- z  out  1  day is the last day of the current month.
- z_year  out  1  z is high and month is 11.

## Operation

- Month length (combinational, from month and leap):
  - month 1 (Feb): 28, or 29 when leap is high.
  - months 3, 5, 8, 10: 30.
  - all other months: 31.
- leap = (year%4==0) && ((year%100!=0) || (year%400==0)), then ANDed with LEAP_EN.
- Precedence per cycle: reset > ld > en > hold.
- Load (ld high): all four registers are taken from the ld_* inputs.
  - ld_month > 11 is stored as 11.
  - ld_dow = 7 is stored as 0.
  - ld_day ≥ the month length (computed from the loaded month and year) is clamped to length−1.
- Advance (en high, ld low):
  - dow ← (dow+1)%7.
  - If z is low: day ← day+1.
  - If z is high: day ← 0 and month ← month+1.
  - If z_year is high: month ← 0 and year ← year+1, wrapping to 0 from 2^YEAR_W−1.
- Hold: every register keeps its value when neither ld nor en is high.
- Out-of-range state can only arise from a corrupted register. It is handled on the next en: if day > length−1, treat z as true.
- Implement the %100 and %400 tests with an incremental or constant-divide structure. Do not use a generic divider.

## Timing

- Reset values (asynchronous, applied while rst is low):
  - day 0, month 0, year RESET_YEAR, dow RESET_DOW.
  - With default parameters: leap 1, z 0, z_year 0.
- All registers update one cycle after the ld or en sample. There is no additional pipeline latency.
- z, z_year and leap are combinational from the current registers. They are valid in the same cycle the registers change, so an upstream chain can gate on en && z.
- Simultaneous ld and en: ld wins and the tick is discarded (not deferred).
- rst asserted mid-operation: outputs go to reset values immediately, regardless of clk.
- Deassertion of rst is expected synchronous to clk from the reset synchroniser. The block takes its first update on the first rising edge with rst high.
- en high on consecutive cycles is legal: one day per cycle.

## Test plan

- Reset/defaults: hold rst low, then release. Expect day 0, month 0, year 2000, dow 6, leap 1, z 0. Assert rst low mid-count and check the outputs clear without a clock edge.
- February, leap: load 27/1/2024, then 2 ticks. Expect day 28 (z=1) after the first tick, then day 0/month 2 after the second. Repeat with year 1900: day 27 gives z=1 and the next tick goes to 0/2. Repeat with year 2000: behaves as a leap year. With LEAP_EN=0 and year 2024: z=1 at day 27.
- 30/31-day months: load 29/3 → z=1, and one tick gives 0/4. Load 29/4 → z=0, and one tick gives 30/4.
- Year rollover: load 30/11/2023, dow 0. One tick gives day 0, month 0, year 2024, dow 1. z_year was 1 before the tick.
- Year wrap and dow: with YEAR_W=12, load 30/11/4095. One tick gives year 0. 7 consecutive ticks from dow 3 return to dow 3.
- Load rules: load day 31/month 1/2023 → day 27. Load month 14 → 11. Load ld_dow 7 → dow 0. Assert ld and en together with 5/5/2020 → exactly 5/5/2020; the tick is not applied.
